// File: rtl/pic_cmd_regs_if.sv
// Host write/read port of the PIC command register block and the decoded configuration it exposes.
// The host side uses modport master; the register block uses modport slave.
interface pic_cmd_regs_if #(
    parameter int N_IRQ = 8
);
    logic             wr;
    logic             rd;
    logic             A0;
    logic [7:0]       DBus;
    logic             LTIM;
    logic             SNGL;
    logic             IC4;
    logic [4:0]       TReg;
    logic [7:0]       SReg;
    logic             SFNM;
    logic             BUF;
    logic             MS;
    logic             AEOI;
    logic             UPM;
    logic [N_IRQ-1:0] MReg;
    logic             initDone;
    logic             ocw2Valid;
    logic             R;
    logic             SL;
    logic             EOI;
    logic [2:0]       level;
    logic             SMM;
    logic             readIRR;
    logic             readISR;
    logic             readIMR;
    logic             readPoll;

    modport master (
        output wr, rd, A0, DBus,
        input  LTIM, SNGL, IC4, TReg, SReg, SFNM, BUF, MS, AEOI, UPM, MReg,
        input  initDone, ocw2Valid, R, SL, EOI, level, SMM,
        input  readIRR, readISR, readIMR, readPoll
    );

    modport slave (
        input  wr, rd, A0, DBus,
        output LTIM, SNGL, IC4, TReg, SReg, SFNM, BUF, MS, AEOI, UPM, MReg,
        output initDone, ocw2Valid, R, SL, EOI, level, SMM,
        output readIRR, readISR, readIMR, readPoll
    );
endinterface

// File: rtl/pic_cmd_regs.sv
// 8259-style ICW/OCW command decoder and register file; writes land at the sampling edge, read selects are combinational.
// No backpressure: every cycle with wr high is one accepted write.
module pic_cmd_regs #(
    parameter int               N_IRQ   = 8,
    parameter logic [N_IRQ-1:0] IMR_RST = '1
) (
    input  logic           clk,
    input  logic           rst_n,
    pic_cmd_regs_if.slave  bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] W_ICW2 = 3'd1;
    localparam logic [2:0] W_ICW3 = 3'd2;
    localparam logic [2:0] W_ICW4 = 3'd3;
    localparam logic [2:0] READY  = 3'd4;

    logic [2:0]       state;
    logic             ltim_r, sngl_r, ic4_r;
    logic [4:0]       treg_r;
    logic [7:0]       sreg_r;
    logic             sfnm_r, buf_r, ms_r, aeoi_r, upm_r;
    logic [N_IRQ-1:0] mreg_r;
    logic             init_done_r, ocw2_vld_r;
    logic             r_r, sl_r, eoi_r;
    logic [2:0]       level_r;
    logic             smm_r, rr_r, ris_r, poll_pend_r;
    logic [7:0]       d;

    assign d = bus.DBus;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ltim_r      <= 1'b0;
            sngl_r      <= 1'b0;
            ic4_r       <= 1'b0;
            treg_r      <= '0;
            sreg_r      <= '0;
            sfnm_r      <= 1'b0;
            buf_r       <= 1'b0;
            ms_r        <= 1'b0;
            aeoi_r      <= 1'b0;
            upm_r       <= 1'b0;
            mreg_r      <= IMR_RST;
            init_done_r <= 1'b0;
            ocw2_vld_r  <= 1'b0;
            r_r         <= 1'b0;
            sl_r        <= 1'b0;
            eoi_r       <= 1'b0;
            level_r     <= '0;
            smm_r       <= 1'b0;
            rr_r        <= 1'b1;
            ris_r       <= 1'b0;
            poll_pend_r <= 1'b0;
        end else begin
            ocw2_vld_r <= 1'b0;
            // A read consumes a pending poll; a write at the same edge may re-arm it below.
            if (bus.rd)
                poll_pend_r <= 1'b0;
            if (bus.wr) begin
                if (!bus.A0 && d[4]) begin
                    ltim_r      <= d[3];
                    sngl_r      <= d[1];
                    ic4_r       <= d[0];
                    mreg_r      <= IMR_RST;
                    smm_r       <= 1'b0;
                    sfnm_r      <= 1'b0;
                    buf_r       <= 1'b0;
                    ms_r        <= 1'b0;
                    aeoi_r      <= 1'b0;
                    upm_r       <= 1'b0;
                    rr_r        <= 1'b1;
                    ris_r       <= 1'b0;
                    poll_pend_r <= 1'b0;
                    init_done_r <= 1'b0;
                    state       <= W_ICW2;
                end else if (bus.A0) begin
                    case (state)
                        W_ICW2: begin
                            treg_r <= d[7:3];
                            if (!sngl_r)
                                state <= W_ICW3;
                            else if (ic4_r)
                                state <= W_ICW4;
                            else begin
                                state       <= READY;
                                init_done_r <= 1'b1;
                            end
                        end
                        W_ICW3: begin
                            sreg_r <= d;
                            if (ic4_r)
                                state <= W_ICW4;
                            else begin
                                state       <= READY;
                                init_done_r <= 1'b1;
                            end
                        end
                        W_ICW4: begin
                            sfnm_r      <= d[4];
                            buf_r       <= d[3];
                            ms_r        <= d[2];
                            aeoi_r      <= d[1];
                            upm_r       <= d[0];
                            state       <= READY;
                            init_done_r <= 1'b1;
                        end
                        READY:   mreg_r <= d[N_IRQ-1:0];
                        default: ;
                    endcase
                end else if (state == READY) begin
                    if (d[3]) begin
                        if (d[6])
                            smm_r <= d[5];
                        if (d[1]) begin
                            rr_r  <= 1'b1;
                            ris_r <= d[0];
                        end
                        if (d[2])
                            poll_pend_r <= 1'b1;
                    end else begin
                        r_r        <= d[7];
                        sl_r       <= d[6];
                        eoi_r      <= d[5];
                        level_r    <= d[2:0];
                        ocw2_vld_r <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.LTIM      = ltim_r;
    assign bus.SNGL      = sngl_r;
    assign bus.IC4       = ic4_r;
    assign bus.TReg      = treg_r;
    assign bus.SReg      = sreg_r;
    assign bus.SFNM      = sfnm_r;
    assign bus.BUF       = buf_r;
    assign bus.MS        = ms_r;
    assign bus.AEOI      = aeoi_r;
    assign bus.UPM       = upm_r;
    assign bus.MReg      = mreg_r;
    assign bus.initDone  = init_done_r;
    assign bus.ocw2Valid = ocw2_vld_r;
    assign bus.R         = r_r;
    assign bus.SL        = sl_r;
    assign bus.EOI       = eoi_r;
    assign bus.level     = level_r;
    assign bus.SMM       = smm_r;

    // Poll outranks the register-read sources so the selects stay one-hot.
    assign bus.readPoll = bus.rd & poll_pend_r;
    assign bus.readIMR  = bus.rd & ~poll_pend_r & bus.A0;
    assign bus.readIRR  = bus.rd & ~poll_pend_r & ~bus.A0 & rr_r & ~ris_r;
    assign bus.readISR  = bus.rd & ~poll_pend_r & ~bus.A0 & rr_r & ris_r;
endmodule

// File: tb/tb_pic_cmd_regs.sv
// Randomised and directed stimulus against a queue-based reference model; a negedge monitor scores every cycle.
module tb_pic_cmd_regs;
    logic clk;
    logic rst_n;

    pic_cmd_regs_if #(.N_IRQ(8)) bus ();

    pic_cmd_regs #(.N_IRQ(8), .IMR_RST(8'hFF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [20:0] icw;
        logic [7:0]  mreg;
        logic [6:0]  ocw2;
        logic [1:0]  ctl;
        logic [3:0]  sel;
    } snap_t;

    snap_t sb[$];
    int    n_pass  = 0;
    int    n_total = 0;

    // Reference model: initialisation tracked as a list of the ICWs still owed.
    bit       m_cfg;
    int       m_pend[$];
    bit       m_ltim, m_sngl, m_ic4;
    bit [4:0] m_treg;
    bit [7:0] m_sreg;
    bit       m_sfnm, m_buf, m_ms, m_aeoi, m_upm;
    bit [7:0] m_mreg;
    bit       m_v, m_r, m_sl, m_eoi;
    bit [2:0] m_level;
    bit       m_smm, m_rr, m_ris, m_poll;

    function automatic bit m_ready();
        return m_cfg && (m_pend.size() == 0);
    endfunction

    task automatic model_reset();
        m_cfg = 0; m_pend.delete();
        m_ltim = 0; m_sngl = 0; m_ic4 = 0; m_treg = 0; m_sreg = 0;
        m_sfnm = 0; m_buf = 0; m_ms = 0; m_aeoi = 0; m_upm = 0;
        m_mreg = 8'hFF; m_v = 0; m_r = 0; m_sl = 0; m_eoi = 0; m_level = 0;
        m_smm = 0; m_rr = 1; m_ris = 0; m_poll = 0;
    endtask

    function automatic snap_t model_snap(bit rd, bit a0);
        snap_t s;
        s.icw  = {m_ltim, m_sngl, m_ic4, m_treg, m_sreg, m_sfnm, m_buf, m_ms, m_aeoi, m_upm};
        s.mreg = m_mreg;
        s.ocw2 = {m_v, m_r, m_sl, m_eoi, m_level};
        s.ctl  = {m_ready(), m_smm};
        s.sel  = 4'b0000;
        if (rd) begin
            if (m_poll)      s.sel = 4'b0001;
            else if (a0)     s.sel = 4'b0010;
            else if (m_rr)   s.sel = m_ris ? 4'b1000 : 4'b0100;
        end
        return s;
    endfunction

    function automatic snap_t dut_snap();
        snap_t s;
        s.icw  = {bus.LTIM, bus.SNGL, bus.IC4, bus.TReg, bus.SReg,
                  bus.SFNM, bus.BUF, bus.MS, bus.AEOI, bus.UPM};
        s.mreg = bus.MReg;
        s.ocw2 = {bus.ocw2Valid, bus.R, bus.SL, bus.EOI, bus.level};
        s.ctl  = {bus.initDone, bus.SMM};
        s.sel  = {bus.readISR, bus.readIRR, bus.readIMR, bus.readPoll};
        return s;
    endfunction

    task automatic model_step(bit wr, bit rd, bit a0, bit [7:0] d);
        int k;
        m_v = 0;
        if (rd) m_poll = 0;
        if (!wr) return;
        if (!a0 && d[4]) begin
            m_ltim = d[3]; m_sngl = d[1]; m_ic4 = d[0];
            m_mreg = 8'hFF; m_smm = 0;
            m_sfnm = 0; m_buf = 0; m_ms = 0; m_aeoi = 0; m_upm = 0;
            m_rr = 1; m_ris = 0; m_poll = 0;
            m_cfg = 1;
            m_pend.delete();
            m_pend.push_back(2);
            if (!d[1]) m_pend.push_back(3);
            if (d[0])  m_pend.push_back(4);
        end else if (a0) begin
            if (m_pend.size() > 0) begin
                k = m_pend.pop_front();
                if (k == 2)      m_treg = d[7:3];
                else if (k == 3) m_sreg = d;
                else             {m_sfnm, m_buf, m_ms, m_aeoi, m_upm} = d[4:0];
            end else if (m_cfg) begin
                m_mreg = d;
            end
        end else if (m_ready()) begin
            if (d[3]) begin
                if (d[6]) m_smm = d[5];
                if (d[1]) begin m_rr = 1; m_ris = d[0]; end
                if (d[2]) m_poll = 1;
            end else begin
                m_v = 1; m_r = d[7]; m_sl = d[6]; m_eoi = d[5]; m_level = d[2:0];
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        else
            n_pass++;
    endtask

    // Drive one cycle's inputs, record what the DUT must show during it, then advance the model.
    task automatic step(bit wr, bit rd, bit a0, bit [7:0] d);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        bus.wr   = wr;
        bus.rd   = rd;
        bus.A0   = a0;
        bus.DBus = d;
        sb.push_back(model_snap(rd, a0));
        model_step(wr, rd, a0, d);
    endtask

    task automatic do_reset();
        snap_t got, exp;
        @(posedge clk);
        #1;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        rst_n  = 1'b0;
        model_reset();
        #1;
        got = dut_snap();
        exp = model_snap(1'b0, 1'b0);
        chk("async_reset_regs", {11'd0, got.icw}, {11'd0, exp.icw});
        chk("async_reset_ctl", {got.mreg, got.ocw2, got.ctl, got.sel},
                               {exp.mreg, exp.ocw2, exp.ctl, exp.sel});
        sb.push_back(exp);
        @(posedge clk);
        #1;
        sb.push_back(model_snap(1'b0, 1'b0));
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            snap_t e, g;
            e = sb.pop_front();
            g = dut_snap();
            chk("icw_fields", {11'd0, g.icw}, {11'd0, e.icw});
            chk("mreg", {24'd0, g.mreg}, {24'd0, e.mreg});
            chk("ocw2", {25'd0, g.ocw2}, {25'd0, e.ocw2});
            chk("init_smm", {30'd0, g.ctl}, {30'd0, e.ctl});
            chk("read_sel", {28'd0, g.sel}, {28'd0, e.sel});
        end
    end

    initial begin
        int t;
        bit [7:0] d;
        rst_n    = 1'b0;
        bus.wr   = 1'b0;
        bus.rd   = 1'b0;
        bus.A0   = 1'b0;
        bus.DBus = 8'h00;
        model_reset();
        do_reset();

        // Single mode with ICW4: ICW3 skipped.
        step(1, 0, 0, 8'h13);
        step(1, 0, 1, 8'h48);
        step(1, 0, 1, 8'h03);
        step(0, 0, 0, 8'h00);
        // Cascade mode without ICW4.
        step(1, 0, 0, 8'h10);
        step(1, 0, 1, 8'h20);
        step(1, 0, 1, 8'h04);
        step(0, 1, 1, 8'h00);
        // Mask, then specific EOI on level 3.
        step(1, 0, 1, 8'hA5);
        step(1, 0, 0, 8'h63);
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        // ISR select, poll, then ISR again.
        step(1, 0, 0, 8'h0B);
        step(0, 1, 0, 8'h00);
        step(1, 0, 0, 8'h0C);
        step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        // Poll re-armed by a write in the same cycle as a read.
        step(1, 1, 0, 8'h0C);
        step(0, 1, 0, 8'h00);
        // Non-ICW1 A0=0 write mid-sequence is ignored; ICW1 restarts.
        step(1, 0, 0, 8'h13);
        step(1, 0, 0, 8'h63);
        step(1, 0, 1, 8'h48);
        step(1, 0, 0, 8'h12);
        step(1, 0, 1, 8'hF8);
        step(1, 1, 1, 8'h5A);
        step(0, 1, 1, 8'h00);
        do_reset();
        step(1, 0, 1, 8'h77);
        step(1, 0, 0, 8'h17);
        step(1, 0, 1, 8'h30);
        step(1, 0, 1, 8'h1F);

        for (int i = 0; i < 600; i++) begin
            t = $urandom_range(0, 15);
            d = 8'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else if (t == 0) begin
                d[4] = 1'b1;
                step(1, $urandom_range(0, 2) == 0, 0, d);
            end else if (t <= 5) begin
                step(1, $urandom_range(0, 2) == 0, 1, d);
            end else if (t <= 9) begin
                d[4] = 1'b0;
                step(1, $urandom_range(0, 2) == 0, 0, d);
            end else begin
                step(0, $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 1, d);
            end
        end

        step(0, 0, 0, 8'h00);
        @(posedge clk);
        @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pic_cmd_regs.md
PIC_CMD_REGS -- requirements
Module: pic_cmd_regs

Interface
REQ-001 Parameter N_IRQ, default 8, number of interrupt request lines served (legal 1..8); mask/level widths follow it.
REQ-002 Parameter IMR_RST, default all-ones, IMR value after reset and after ICW1.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 wr  in  1  write strobe; each cycle sampled high = one write.
REQ-006 rd  in  1  read strobe, level.
REQ-007 A0  in  1  port address.
REQ-008 DBus  in  8  write data.
REQ-009 LTIM, SNGL, IC4  out  1 each  ICW1 fields D3, D1, D0.
REQ-010 TReg  out  5  vector base, ICW2 D7:3.
REQ-011 SReg  out  8  cascade word, ICW3.
REQ-012 SFNM, BUF, MS, AEOI, UPM  out  1 each  ICW4 D4, D3, D2, D1, D0.
REQ-013 MReg  out  N_IRQ  interrupt mask, OCW1 D[N_IRQ-1:0].
REQ-014 initDone  out  1  initialisation sequence complete.
REQ-015 ocw2Valid  out  1  one-cycle pulse qualifying R, SL, EOI, level.
REQ-016 R, SL, EOI  out  1 each; level  out  3  OCW2 D7, D6, D5, D2:0.
REQ-017 SMM  out  1  special mask mode.
REQ-018 readIRR, readISR, readIMR, readPoll  out  1 each  read-source selects, one-hot or all zero.

Function
REQ-019 Decode per write: A0=0 & D4=1 -> ICW1 (accepted in any state); A0=0 & D4=0 & D3=0 -> OCW2; A0=0 & D4=0 & D3=1 -> OCW3; A0=1 -> ICW2/3/4 per state, else OCW1.
REQ-020 FSM states IDLE, W_ICW2, W_ICW3, W_ICW4, READY; reset -> IDLE.
REQ-021 ICW1: latch LTIM/SNGL/IC4; MReg<=IMR_RST; SMM, SFNM, BUF, MS, AEOI, UPM <= 0; RR<=1, RIS<=0, poll pending<=0; initDone<=0; -> W_ICW2.
REQ-022 W_ICW2 + A0=1 write: TReg<=D7:3; -> W_ICW3 if SNGL=0, else W_ICW4 if IC4=1, else READY.
REQ-023 W_ICW3 + A0=1 write: SReg<=DBus; -> W_ICW4 if IC4=1, else READY.
REQ-024 W_ICW4 + A0=1 write: latch ICW4 fields; -> READY.
REQ-025 initDone=1 exactly while state=READY, registered with the transition edge.
REQ-026 In IDLE/W_ICWx, A0=0 non-ICW1 writes are ignored, no state or output change.
REQ-027 OCW1/OCW2/OCW3 act only in READY.
REQ-028 OCW2: R, SL, EOI, level registered; ocw2Valid high exactly one cycle after the write edge; R/SL/EOI/level hold until next OCW2.
REQ-029 OCW3: D6=1 -> SMM<=D5, else SMM unchanged; D1=1 -> RR<=1, RIS<=D0, else RR/RIS unchanged; D2=1 -> poll pending<=1.
REQ-030 Read selects combinational from registered state, gated by rd: readPoll=rd & pollPending; else readIMR=rd & A0; readIRR=rd & ~A0 & RR & ~RIS; readISR=rd & ~A0 & RR & RIS.
REQ-031 Poll pending clears at the first rising edge with rd=1; RR/RIS unaffected by poll.
REQ-032 wr and rd in the same cycle: read selects reflect pre-write state; write takes effect at that edge.
REQ-033 N_IRQ<8: DBus bits above N_IRQ-1 ignored in OCW1; level passed unmodified.

Reset
REQ-034 rst_n=0 asynchronously: state IDLE; all outputs 0 except MReg=IMR_RST; RR=1, RIS=0, poll pending=0.
REQ-035 Deassertion synchronous to clk; first write accepted on the first edge with rst_n=1.

Verification
REQ-036 Reset, ICW1=0x13 (SNGL=1, IC4=1), ICW2=0x48, ICW4=0x03 -> TReg=0x09, AEOI=1, UPM=1, ICW3 skipped, initDone=1 after third write.
REQ-037 ICW1=0x10, ICW2=0x20, ICW3=0x04 -> READY after ICW3, SFNM=AEOI=0, SReg=0x04.
REQ-038 READY, OCW1=0xA5 then OCW2=0x63 -> MReg=0xA5; ocw2Valid single cycle with SL=1, EOI=1, level=3.
REQ-039 OCW3=0x0B, rd=1 A0=0 -> readISR=1; OCW3=0x0C, rd=1 -> readPoll one cycle, then readISR=1 (RR/RIS retained).
REQ-040 Mid-sequence ICW1 after ICW2 -> restart at W_ICW2, initDone=0, MReg=IMR_RST; rst_n pulse in READY -> all outputs at reset values same cycle.
